// File: rtl/hilo_pkg.sv
// Shared constants for the HI/LO result controller: FSM encodings, HI/LO select codes,
// the default data width and a small helper for the counter saturation bound.
package hilo_pkg;
  localparam int HILO_DATA_W = 32;

  localparam logic [1:0] HILO_IDLE     = 2'd0;
  localparam logic [1:0] HILO_WAIT_MUL = 2'd1;
  localparam logic [1:0] HILO_WAIT_DIV = 2'd2;

  localparam logic MT_SEL_LO = 1'b0;
  localparam logic MT_SEL_HI = 1'b1;

  function automatic int hilo_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/hilo_if.sv
// Bus between the EX stage / mul-div units and the HI/LO controller.
// Strobes (issue_*, mul_ce, div_done, mt_we, rd_req) are single-cycle qualifiers; rd_data is valid only with rd_valid.
interface hilo_if
  import hilo_pkg::*;
#(
  parameter int DATA_W = HILO_DATA_W
);
  logic              flush;
  logic              issue_mul;
  logic              issue_div;
  logic              mul_ce;
  logic [DATA_W-1:0] mul_hi;
  logic [DATA_W-1:0] mul_lo;
  logic              div_done;
  logic [DATA_W-1:0] div_rem;
  logic [DATA_W-1:0] div_quo;
  logic              mt_we;
  logic              mt_sel;
  logic [DATA_W-1:0] mt_data;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              stall_req;
  logic              busy;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              err_latency;
  logic              err_timeout;
  logic [1:0]        state;

  modport master (
    output flush, issue_mul, issue_div, mul_ce, mul_hi, mul_lo,
           div_done, div_rem, div_quo, mt_we, mt_sel, mt_data, rd_req,
    input  rd_data, rd_valid, stall_req, busy, hi, lo,
           err_latency, err_timeout, state
  );

  modport slave (
    input  flush, issue_mul, issue_div, mul_ce, mul_hi, mul_lo,
           div_done, div_rem, div_quo, mt_we, mt_sel, mt_data, rd_req,
    output rd_data, rd_valid, stall_req, busy, hi, lo,
           err_latency, err_timeout, state
  );
endinterface

// File: rtl/hilo_latency_cnt.sv
// Cycle counter for the in-flight mul/div op: loads 1 on issue, counts while busy,
// saturates one past the larger limit and exposes the latency/timeout compare flags.
module hilo_latency_cnt
  import hilo_pkg::*;
#(
  parameter int MUL_LATENCY = 6,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic mul_hit_o,
  output logic mul_over_o,
  output logic div_to_o
);
  localparam int CNT_MAX = hilo_max(MUL_LATENCY, DIV_TIMEOUT) + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MUL_LATENCY);
  localparam logic [CNT_W-1:0] DIV_TO  = CNT_W'(DIV_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = CNT_W'(1);
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mul_hit_o  = (cnt_q == MUL_LAT);
  assign mul_over_o = (cnt_q > MUL_LAT);
  assign div_to_o   = (cnt_q == DIV_TO);
endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO architectural registers with mul/div result commit, MTHI/MTLO/MFHI/MFLO service,
// EX-stage stall generation and latency/timeout checking of the single in-flight op.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int DATA_W      = HILO_DATA_W,
  parameter int MUL_LATENCY = 6,
  parameter int DIV_TIMEOUT = 40
) (
  input logic  clk,
  input logic  reset,
  hilo_if.slave bus
);
  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              drop_div_q, drop_div_d;
  logic              err_lat_q, err_lat_d;
  logic              err_to_q, err_to_d;
  logic              cnt_start, cnt_clr;
  logic              mul_hit, mul_over, div_to;
  logic              idle, acc_mul, acc_div, accepted, mt_wr;
  logic [DATA_W-1:0] rd_data_c;

  assign idle     = (state_q == HILO_IDLE);
  assign acc_mul  = (state_q == HILO_WAIT_MUL) & bus.mul_ce & ~bus.flush;
  assign acc_div  = (state_q == HILO_WAIT_DIV) & bus.div_done & ~bus.flush;
  assign accepted = acc_mul | acc_div;
  // A move is not stalled in a result-accept cycle, so it must land then too (after the result).
  assign mt_wr    = bus.mt_we & (idle | accepted) & ~bus.flush;

  hilo_latency_cnt #(
    .MUL_LATENCY (MUL_LATENCY),
    .DIV_TIMEOUT (DIV_TIMEOUT)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .start_i    (cnt_start),
    .clr_i      (cnt_clr),
    .inc_i      (~idle),
    .mul_hit_o  (mul_hit),
    .mul_over_o (mul_over),
    .div_to_o   (div_to)
  );

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    drop_div_d = drop_div_q;
    err_lat_d  = err_lat_q;
    err_to_d   = err_to_q;
    cnt_start  = 1'b0;
    cnt_clr    = 1'b0;

    if (bus.flush) begin
      state_d = HILO_IDLE;
      cnt_clr = 1'b1;
      if (state_q == HILO_WAIT_DIV) drop_div_d = 1'b1;
    end else begin
      if (bus.issue_mul || bus.issue_div) begin
        if (!idle) begin
          err_lat_d = 1'b1;
        end else if (bus.issue_mul) begin
          state_d   = HILO_WAIT_MUL;
          cnt_start = 1'b1;
          if (bus.issue_div) err_lat_d = 1'b1;
        end else begin
          state_d   = HILO_WAIT_DIV;
          cnt_start = 1'b1;
        end
      end

      if (bus.mul_ce && state_q != HILO_WAIT_MUL) err_lat_d = 1'b1;
      // A late strobe from a flushed/timed-out divide is expected exactly once.
      if (bus.div_done && state_q != HILO_WAIT_DIV) begin
        drop_div_d = 1'b0;
        if (!drop_div_q) err_lat_d = 1'b1;
      end

      case (state_q)
        HILO_WAIT_MUL: begin
          if (bus.mul_ce) begin
            hi_d    = bus.mul_hi;
            lo_d    = bus.mul_lo;
            state_d = HILO_IDLE;
            cnt_clr = 1'b1;
            if (!mul_hit) err_lat_d = 1'b1;
          end else if (mul_over) begin
            err_lat_d = 1'b1;
            state_d   = HILO_IDLE;
            cnt_clr   = 1'b1;
          end
        end
        HILO_WAIT_DIV: begin
          if (bus.div_done) begin
            hi_d    = bus.div_rem;
            lo_d    = bus.div_quo;
            state_d = HILO_IDLE;
            cnt_clr = 1'b1;
          end else if (div_to) begin
            err_to_d   = 1'b1;
            drop_div_d = 1'b1;
            state_d    = HILO_IDLE;
            cnt_clr    = 1'b1;
          end
        end
        default: ;
      endcase

      if (mt_wr) begin
        if (bus.mt_sel == MT_SEL_HI) hi_d = bus.mt_data;
        else                         lo_d = bus.mt_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HILO_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      drop_div_q <= 1'b0;
      err_lat_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      drop_div_q <= drop_div_d;
      err_lat_q  <= err_lat_d;
      err_to_q   <= err_to_d;
    end
  end

  always_comb begin
    rd_data_c = (bus.mt_sel == MT_SEL_HI) ? hi_q : lo_q;
    if (acc_mul) rd_data_c = (bus.mt_sel == MT_SEL_HI) ? bus.mul_hi : bus.mul_lo;
    if (acc_div) rd_data_c = (bus.mt_sel == MT_SEL_HI) ? bus.div_rem : bus.div_quo;
    if (mt_wr)   rd_data_c = bus.mt_data;
  end

  assign bus.rd_data     = rd_data_c;
  assign bus.rd_valid    = bus.rd_req & (idle | accepted);
  assign bus.busy        = ~idle;
  assign bus.stall_req   = (bus.rd_req | bus.mt_we) & ~idle & ~accepted;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.err_latency = err_lat_q;
  assign bus.err_timeout = err_to_q;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl: one task per scenario, each with its own hand-computed checks.
module tb_hilo_ctrl;
  import hilo_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  hilo_if #(.DATA_W(32)) bus ();

  hilo_ctrl #(.DATA_W(32), .MUL_LATENCY(6), .DIV_TIMEOUT(40)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.flush = 0; bus.issue_mul = 0; bus.issue_div = 0;
    bus.mul_ce = 0; bus.mul_hi = '0; bus.mul_lo = '0;
    bus.div_done = 0; bus.div_rem = '0; bus.div_quo = '0;
    bus.mt_we = 0; bus.mt_sel = 0; bus.mt_data = '0; bus.rd_req = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall_req); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
    checks++; if ({bus.err_latency, bus.err_timeout} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", {bus.err_latency, bus.err_timeout}); end
    checks++; if (bus.state !== HILO_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_mul_basic();
    bus.issue_mul = 1;
    step();
    bus.issue_mul = 0;
    for (int k = 1; k <= 5; k++) begin
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mul_busy t%0d: got %b expected 1", k, bus.busy); end
      step();
    end
    bus.mul_ce = 1; bus.mul_hi = 32'h1; bus.mul_lo = 32'hFFFF_FFFE;
    #1;
    checks++; if (bus.busy !== 1'b1 || bus.hi !== 32'h0) begin errors++; $display("FAIL mul_t6: got busy=%b hi=%h expected busy=1 hi=0", bus.busy, bus.hi); end
    step();
    clear_inputs();
    checks++; if (bus.hi !== 32'h1) begin errors++; $display("FAIL mul_hi: got %h expected 1", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mul_lo: got %h expected fffffffe", bus.lo); end
    checks++; if (bus.busy !== 1'b0 || bus.err_latency !== 1'b0) begin errors++; $display("FAIL mul_done: got busy=%b err=%b expected 0 0", bus.busy, bus.err_latency); end
  endtask

  task automatic test_read_stall();
    bus.issue_mul = 1;
    step();
    bus.issue_mul = 0;
    step();
    step();
    bus.rd_req = 1; bus.mt_sel = MT_SEL_HI;
    for (int k = 3; k <= 5; k++) begin
      #1;
      checks++; if (bus.stall_req !== 1'b1 || bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rd_stall t%0d: got stall=%b valid=%b expected 1 0", k, bus.stall_req, bus.rd_valid); end
      step();
    end
    bus.mul_ce = 1; bus.mul_hi = 32'hDEAD_BEEF; bus.mul_lo = 32'h1234_5678;
    #1;
    checks++; if (bus.rd_valid !== 1'b1 || bus.stall_req !== 1'b0) begin errors++; $display("FAIL rd_fwd_ctl: got valid=%b stall=%b expected 1 0", bus.rd_valid, bus.stall_req); end
    checks++; if (bus.rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_fwd_data: got %h expected deadbeef", bus.rd_data); end
    step();
    clear_inputs();
    checks++; if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== 32'h1234_5678) begin errors++; $display("FAIL rd_commit: got hi=%h lo=%h expected deadbeef 12345678", bus.hi, bus.lo); end
  endtask

  task automatic test_mul_early();
    bus.issue_mul = 1;
    step();
    bus.issue_mul = 0;
    step(); step(); step();
    bus.mul_ce = 1; bus.mul_hi = 32'h11; bus.mul_lo = 32'h22;
    step();
    clear_inputs();
    checks++; if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin errors++; $display("FAIL early_commit: got hi=%h lo=%h expected 11 22", bus.hi, bus.lo); end
    checks++; if (bus.err_latency !== 1'b1) begin errors++; $display("FAIL early_err: got %b expected 1", bus.err_latency); end
    checks++; if (bus.state !== HILO_IDLE) begin errors++; $display("FAIL early_state: got %0d expected 0", bus.state); end
  endtask

  task automatic test_mul_late();
    do_reset();
    bus.issue_mul = 1;
    step();
    bus.issue_mul = 0;
    for (int k = 1; k < 7; k++) step();
    checks++; if (bus.busy !== 1'b1 || bus.err_latency !== 1'b0) begin errors++; $display("FAIL late_t7: got busy=%b err=%b expected 1 0", bus.busy, bus.err_latency); end
    step();
    checks++; if (bus.busy !== 1'b0 || bus.err_latency !== 1'b1) begin errors++; $display("FAIL late_t8: got busy=%b err=%b expected 0 1", bus.busy, bus.err_latency); end
  endtask

  task automatic test_both_issue();
    do_reset();
    bus.issue_mul = 1; bus.issue_div = 1;
    step();
    clear_inputs();
    checks++; if (bus.state !== HILO_WAIT_MUL) begin errors++; $display("FAIL both_state: got %0d expected 1", bus.state); end
    checks++; if (bus.err_latency !== 1'b1) begin errors++; $display("FAIL both_err: got %b expected 1", bus.err_latency); end
  endtask

  task automatic test_div_flush();
    do_reset();
    bus.issue_div = 1;
    step();
    bus.issue_div = 0;
    step(); step(); step(); step();
    bus.flush = 1;
    #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL flush_busy: got %b expected 1", bus.busy); end
    step();
    bus.flush = 0;
    checks++; if (bus.state !== HILO_IDLE) begin errors++; $display("FAIL flush_state: got %0d expected 0", bus.state); end
    for (int k = 6; k < 20; k++) step();
    bus.div_done = 1; bus.div_rem = 32'hAAAA; bus.div_quo = 32'hBBBB;
    step();
    clear_inputs();
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL flush_drop: got hi=%h lo=%h expected 0 0", bus.hi, bus.lo); end
    checks++; if (bus.err_latency !== 1'b0) begin errors++; $display("FAIL flush_err: got %b expected 0", bus.err_latency); end
    bus.div_done = 1;
    step();
    clear_inputs();
    checks++; if (bus.err_latency !== 1'b1) begin errors++; $display("FAIL stray_div_err: got %b expected 1", bus.err_latency); end
  endtask

  task automatic test_div_timeout();
    do_reset();
    bus.issue_div = 1;
    step();
    bus.issue_div = 0;
    for (int k = 1; k < 39; k++) step();
    checks++; if (bus.busy !== 1'b1 || bus.err_timeout !== 1'b0) begin errors++; $display("FAIL to_t39: got busy=%b err=%b expected 1 0", bus.busy, bus.err_timeout); end
    step();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL to_t40: got busy=%b expected 1", bus.busy); end
    step();
    checks++; if (bus.busy !== 1'b0 || bus.err_timeout !== 1'b1) begin errors++; $display("FAIL to_t41: got busy=%b err=%b expected 0 1", bus.busy, bus.err_timeout); end
    bus.mt_we = 1; bus.mt_sel = MT_SEL_LO; bus.mt_data = 32'h1234;
    step();
    clear_inputs();
    checks++; if (bus.lo !== 32'h1234 || bus.hi !== 32'h0) begin errors++; $display("FAIL to_mtlo: got hi=%h lo=%h expected 0 1234", bus.hi, bus.lo); end
    bus.div_done = 1;
    step();
    clear_inputs();
    checks++; if (bus.err_latency !== 1'b0) begin errors++; $display("FAIL to_late_done: got %b expected 0", bus.err_latency); end
  endtask

  task automatic test_div_normal();
    bus.issue_div = 1;
    step();
    bus.issue_div = 0;
    for (int k = 1; k < 10; k++) step();
    bus.div_done = 1; bus.div_rem = 32'h5; bus.div_quo = 32'h7;
    bus.rd_req = 1; bus.mt_sel = MT_SEL_LO;
    #1;
    checks++; if (bus.rd_valid !== 1'b1 || bus.stall_req !== 1'b0) begin errors++; $display("FAIL div_fwd_ctl: got valid=%b stall=%b expected 1 0", bus.rd_valid, bus.stall_req); end
    checks++; if (bus.rd_data !== 32'h7) begin errors++; $display("FAIL div_fwd_data: got %h expected 7", bus.rd_data); end
    step();
    clear_inputs();
    checks++; if (bus.hi !== 32'h5 || bus.lo !== 32'h7) begin errors++; $display("FAIL div_commit: got hi=%h lo=%h expected 5 7", bus.hi, bus.lo); end
    checks++; if (bus.err_latency !== 1'b0) begin errors++; $display("FAIL div_err: got %b expected 0", bus.err_latency); end
  endtask

  task automatic test_mt_fwd();
    bus.mt_we = 1; bus.mt_sel = MT_SEL_HI; bus.mt_data = 32'hA5A5_A5A5; bus.rd_req = 1;
    #1;
    checks++; if (bus.rd_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mt_fwd_data: got %h expected a5a5a5a5", bus.rd_data); end
    checks++; if (bus.rd_valid !== 1'b1 || bus.stall_req !== 1'b0) begin errors++; $display("FAIL mt_fwd_ctl: got valid=%b stall=%b expected 1 0", bus.rd_valid, bus.stall_req); end
    step();
    clear_inputs();
    checks++; if (bus.hi !== 32'hA5A5_A5A5 || bus.lo !== 32'h7) begin errors++; $display("FAIL mt_write: got hi=%h lo=%h expected a5a5a5a5 7", bus.hi, bus.lo); end
  endtask

  task automatic test_mt_stall();
    bus.issue_mul = 1;
    step();
    bus.issue_mul = 0;
    step();
    bus.mt_we = 1; bus.mt_sel = MT_SEL_LO; bus.mt_data = 32'h55;
    #1;
    checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL mt_stall: got %b expected 1", bus.stall_req); end
    step();
    clear_inputs();
    checks++; if (bus.lo !== 32'h7) begin errors++; $display("FAIL mt_blocked: got lo=%h expected 7", bus.lo); end
    step(); step(); step();
    bus.mul_ce = 1; bus.mul_hi = 32'h9; bus.mul_lo = 32'hA;
    step();
    clear_inputs();
    checks++; if (bus.hi !== 32'h9 || bus.lo !== 32'hA || bus.err_latency !== 1'b0) begin errors++; $display("FAIL mt_then_mul: got hi=%h lo=%h err=%b expected 9 a 0", bus.hi, bus.lo, bus.err_latency); end
  endtask

  task automatic test_reset_async();
    bus.mt_we = 1; bus.mt_sel = MT_SEL_HI; bus.mt_data = 32'hCAFE;
    step();
    clear_inputs();
    bus.issue_mul = 1;
    step();
    bus.issue_mul = 0;
    step();
    bus.rd_req = 1; bus.mt_sel = MT_SEL_HI;
    #1;
    checks++; if (bus.stall_req !== 1'b1 || bus.hi !== 32'hCAFE) begin errors++; $display("FAIL pre_reset: got stall=%b hi=%h expected 1 cafe", bus.stall_req, bus.hi); end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL async_hilo: got hi=%h lo=%h expected 0 0", bus.hi, bus.lo); end
    checks++; if (bus.busy !== 1'b0 || bus.stall_req !== 1'b0) begin errors++; $display("FAIL async_ctl: got busy=%b stall=%b expected 0 0", bus.busy, bus.stall_req); end
    clear_inputs();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_read_stall();
    test_mul_early();
    test_mul_late();
    test_both_issue();
    test_div_flush();
    test_div_timeout();
    test_div_normal();
    test_mt_fwd();
    test_mt_stall();
    test_reset_async();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
